// File: rtl/vc_domain_queue_reg_pkg.sv
// Shared definitions for the domain-safe elastic queue: FSM state encodings
// and the pointer-width helper used by the top level and its controller.
`ifndef VC_DOMAIN_QUEUE_DEFS
`define VC_DOMAIN_QUEUE_DEFS

package vc_domain_queue_reg_pkg;

    typedef enum logic {
        VC_DQ_STATE_RUN   = 1'b0,
        VC_DQ_STATE_SCRUB = 1'b1
    } vc_dq_state_e;

    // A single-entry queue still needs a 1-bit pointer to index storage.
    function automatic int vc_dq_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`endif

// File: rtl/vc_domain_queue_reg_ctrl.sv
// Controller for vc_domain_queue_reg: FSM, pointers, occupancy, scrub index and
// domain tracking. Optional zero-latency bypass under VC_DOMAIN_QUEUE_BYPASS_EN.
module vc_domain_queue_ctrl
    import vc_domain_queue_reg_pkg::*;
#(
    parameter int p_depth = 2,
    localparam int c_pw = vc_dq_ptr_width(p_depth)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            domain,
    input  logic            in_val,
    input  logic            out_rdy,
    output logic            in_rdy,
    output logic            out_val,
    output logic            scrub_busy,
    output logic            scrubbing,
    output logic            bypass,
    output logic            wen,
    output logic [c_pw-1:0] widx,
    output logic            wsel_scrub,
    output logic [c_pw-1:0] deq_ptr
);

    localparam int c_cw = $clog2(p_depth + 1);
    localparam logic [c_pw-1:0] c_last = c_pw'(p_depth - 1);
    localparam logic [c_cw-1:0] c_full = c_cw'(p_depth);

    vc_dq_state_e    state, state_n;
    logic [c_pw-1:0] enq_ptr, enq_ptr_n, deq_ptr_n, scrub_idx, scrub_idx_n;
    logic [c_cw-1:0] count, count_n;
    logic            prev_domain, sw, enq, deq;

    function automatic logic [c_pw-1:0] wrap_inc(input logic [c_pw-1:0] p);
        return (p == c_last) ? '0 : p + c_pw'(1);
    endfunction

    assign sw        = (domain != prev_domain);
    assign scrubbing = (state == VC_DQ_STATE_SCRUB);

`ifdef VC_DOMAIN_QUEUE_BYPASS_EN
    assign bypass = (state == VC_DQ_STATE_RUN) && !sw && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        enq_ptr_n   = enq_ptr;
        deq_ptr_n   = deq_ptr;
        count_n     = count;
        scrub_idx_n = scrub_idx;
        in_rdy      = 1'b0;
        out_val     = 1'b0;
        scrub_busy  = 1'b0;
        wen         = 1'b0;
        widx        = enq_ptr;
        wsel_scrub  = 1'b0;
        enq         = 1'b0;
        deq         = 1'b0;
        case (state)
            VC_DQ_STATE_RUN: begin
                if (sw) begin
                    // Drop everything so no payload survives into the new domain.
                    scrub_busy  = 1'b1;
                    state_n     = VC_DQ_STATE_SCRUB;
                    enq_ptr_n   = '0;
                    deq_ptr_n   = '0;
                    count_n     = '0;
                    scrub_idx_n = '0;
                end else begin
                    in_rdy  = (count < c_full);
                    out_val = (count != '0) || (bypass && in_val);
                    enq     = in_val && in_rdy && !(bypass && out_rdy);
                    deq     = out_val && out_rdy && (count != '0);
                    wen     = enq;
                    if (enq) enq_ptr_n = wrap_inc(enq_ptr);
                    if (deq) deq_ptr_n = wrap_inc(deq_ptr);
                    if (enq && !deq)
                        count_n = count + c_cw'(1);
                    else if (deq && !enq)
                        count_n = count - c_cw'(1);
                end
            end
            VC_DQ_STATE_SCRUB: begin
                scrub_busy = 1'b1;
                wen        = 1'b1;
                widx       = scrub_idx;
                wsel_scrub = 1'b1;
                if (sw) begin
                    scrub_idx_n = '0;
                end else if (scrub_idx == c_last) begin
                    scrub_idx_n = '0;
                    state_n     = VC_DQ_STATE_RUN;
                end else begin
                    scrub_idx_n = scrub_idx + c_pw'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        prev_domain <= domain;
        if (reset) begin
            state     <= VC_DQ_STATE_RUN;
            enq_ptr   <= '0;
            deq_ptr   <= '0;
            count     <= '0;
            scrub_idx <= '0;
        end else begin
            state     <= state_n;
            enq_ptr   <= enq_ptr_n;
            deq_ptr   <= deq_ptr_n;
            count     <= count_n;
            scrub_idx <= scrub_idx_n;
        end
    end

endmodule

// File: rtl/vc_domain_queue_reg.sv
// Domain-safe elastic register queue: storage array and output mux around
// vc_domain_queue_ctrl. Optional bypass path under VC_DOMAIN_QUEUE_BYPASS_EN.
module vc_domain_queue_reg
    import vc_domain_queue_reg_pkg::*;
#(
    parameter int               p_nbits       = 8,
    parameter int               p_depth       = 2,
    parameter logic [p_nbits-1:0] p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               domain,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               scrub_busy
);

    localparam int c_pw = vc_dq_ptr_width(p_depth);

    logic [p_nbits-1:0] mem [p_depth];
    logic               wen, wsel_scrub, scrubbing, bypass;
    logic [c_pw-1:0]    widx, deq_ptr;

    vc_domain_queue_ctrl #(.p_depth(p_depth)) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .domain     (domain),
        .in_val     (in_val),
        .out_rdy    (out_rdy),
        .in_rdy     (in_rdy),
        .out_val    (out_val),
        .scrub_busy (scrub_busy),
        .scrubbing  (scrubbing),
        .bypass     (bypass),
        .wen        (wen),
        .widx       (widx),
        .wsel_scrub (wsel_scrub),
        .deq_ptr    (deq_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_depth; i++)
                mem[i] <= p_reset_value;
        end else if (wen) begin
            mem[widx] <= wsel_scrub ? p_reset_value : in_msg;
        end
    end

    // Scrub masks storage entirely; bypass forwards only while the queue is empty.
    always_comb begin
        out_msg = mem[deq_ptr];
        if (scrubbing)
            out_msg = p_reset_value;
        else if (bypass)
            out_msg = in_msg;
    end

endmodule

// File: doc/vc_domain_queue_reg.md
Name: vc_domain_queue_reg

Overview:
- Parametrised successor to the single enable/reset register: a p_depth-entry elastic register queue with a val/rdy handshake on both sides.
- Carries a security-domain tag, so all payload storage and ports are labelled {Domain domain}; clk, reset and domain are {L}.
- On any domain switch, the block flushes all entries and scrubs storage to p_reset_value before accepting traffic again, so no payload crosses domains.
- Sits between ring-network router stages as a domain-safe pipeline buffer.

Parameters:
- p_nbits, 8, payload width in bits (>=1).
- p_depth, 2, number of queue entries (>=1; need not be a power of two).
- p_reset_value, 0, value written to every entry on reset and on scrub.

Ports:
- clk, input, 1, clock; label {L}.
- reset, input, 1, synchronous active-high reset sampled on the rising edge; label {L}.
- domain, input, 1, current security domain; label {L}.
- in_val, input, 1, enqueue request; label {Domain domain}.
- in_rdy, output, 1, queue can accept; label {Domain domain}.
- in_msg, input, p_nbits, enqueue payload; label {Domain domain}.
- out_val, output, 1, head entry valid; label {Domain domain}.
- out_rdy, input, 1, consumer accepts head; label {Domain domain}.
- out_msg, output, p_nbits, head payload; label {Domain domain}.
- scrub_busy, output, 1, high while a flush or scrub is pending or in progress; label {L}.

Behaviour:
- Storage: p_depth x p_nbits array, enq_ptr, deq_ptr, count (width $clog2(p_depth+1)), prev_domain, FSM state {RUN, SCRUB}, scrub_idx.
- Reset, synchronous with priority over everything:
  - state=RUN; enq_ptr=deq_ptr=count=scrub_idx=0; all entries=p_reset_value; prev_domain=domain.
  - Cycle after reset: in_rdy=1, out_val=0, out_msg=p_reset_value, scrub_busy=0.
- sw (domain switch) = (domain != prev_domain). prev_domain <= domain every cycle.
- RUN, no switch:
  - in_rdy = (count < p_depth); it does not depend on out_rdy, so a full queue blocks enqueue even when dequeuing.
  - out_val = (count > 0). out_msg = entry[deq_ptr].
  - Enqueue on in_val&in_rdy: entry[enq_ptr] <= in_msg; enq_ptr advances.
  - Dequeue on out_val&out_rdy: deq_ptr advances.
  - Pointers wrap from p_depth-1 to 0.
  - count +1 on enqueue only, -1 on dequeue only, unchanged when both occur.
  - Minimum latency from in_msg to out_msg is 1 cycle.
- RUN with sw=1 (switch cycle):
  - in_rdy=0, out_val=0, scrub_busy=1; no enqueue or dequeue fires.
  - Next state SCRUB; count, enq_ptr, deq_ptr and scrub_idx all go to 0. All entries are dropped.
- SCRUB:
  - in_rdy=0, out_val=0, out_msg=p_reset_value, scrub_busy=1.
  - Each cycle entry[scrub_idx] <= p_reset_value and scrub_idx increments.
  - After writing index p_depth-1, next state is RUN. SCRUB therefore lasts exactly p_depth cycles.
  - sw during SCRUB restarts scrub_idx at 0 and stays in SCRUB.
- Reset mid-SCRUB or mid-traffic follows the reset rule above; in-flight data is lost.
- When out_val=0, out_msg shows entry[deq_ptr] in RUN and p_reset_value in SCRUB. Consumers must ignore out_msg whenever out_val=0.

Optional Feature:
- VC_DOMAIN_QUEUE_BYPASS_EN.
- Defined: in RUN with count==0 and sw=0, out_val=in_val and out_msg=in_msg combinationally. If out_rdy is also high, the message is consumed with zero latency and not stored; count and pointers are unchanged. in_rdy is unchanged by bypass.
- Undefined: no combinational in->out path; minimum latency is 1 cycle.

Decomposition:
- Shared header vc-domain-queue-defs.v, include-guarded, holds:
  - state encodings VC_DQ_STATE_RUN=1'b0 and VC_DQ_STATE_SCRUB=1'b1;
  - the pointer-width helper.
- One sub-module: vc_domain_queue_ctrl. It contains the FSM, pointers, count, scrub_idx and prev_domain, and produces write enable, write index and write-data select.
- The top level holds the storage array and the output mux.

Test Plan:
- p_nbits=8, p_depth=3. After reset, enqueue 0x11, 0x22, 0x33 with out_rdy=0 -> in_rdy=0 after the third enqueue, count=3; then out_rdy=1 -> out_msg 0x11, 0x22, 0x33 on consecutive cycles.
- Full queue with in_val=1 and out_rdy=1 together -> dequeue occurs, no enqueue that cycle, count 3->2; next cycle both fire and count holds at 2. Covers pointer wrap 2->0.
- Two entries queued, then domain 0->1 -> switch cycle shows in_rdy=0, out_val=0, scrub_busy=1; 3 SCRUB cycles follow; then RUN with count=0 and all entries=0x00. Old payloads never appear on out_msg.
- Domain toggles again on the 2nd SCRUB cycle -> scrub restarts, so scrub_busy stays high for 1+3 further cycles.
- Reset asserted during SCRUB -> next cycle RUN, in_rdy=1, out_val=0, scrub_busy=0.
- With VC_DOMAIN_QUEUE_BYPASS_EN, empty queue, in_val=1, in_msg=0xA5, out_rdy=1 -> out_val=1 and out_msg=0xA5 in the same cycle, count stays 0. Without the macro, 0xA5 appears one cycle later.
